// File: rtl/gascon_pkg.sv
// ---------------------------------------------------------------------------
// gascon_pkg
//   Shared definitions for the Gascon permutation datapath.
//   - GASCON_CWIDTH      : permutation state width in bits
//   - GASCON_MAX_ROUNDS  : rounds in the full permutation (p12)
//   - seq_state_t        : multi-round sequencer FSM encoding
//   - rc()               : round-constant byte for an absolute round index
// ---------------------------------------------------------------------------
package gascon_pkg;

    localparam int GASCON_CWIDTH     = 320;
    localparam int GASCON_MAX_ROUNDS = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Round constant for absolute round index ridx: high nibble counts down
    // from 0xF while the low nibble counts up, e.g. ridx 0 -> 0xF0, 11 -> 0x4B.
    function automatic logic [7:0] rc(input logic [3:0] ridx);
        logic [3:0] w_hi;
        w_hi = 4'hF - ridx;
        return {w_hi, ridx};
    endfunction

endpackage

// File: rtl/gascon_perm_sequencer.sv
// ---------------------------------------------------------------------------
// gascon_perm_sequencer
//   Multi-round controller in front of the single-round Gascon core. Accepts
//   a state plus a round count, drives the core one round at a time (feeding
//   each round result back in) and returns the permuted state.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both 1. A producer holds valid and its data stable
//   until that edge; ready may change freely and never depends on valid.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   in_valid     in   in_state / in_nrounds are valid
//   in_ready     out  sequencer can accept a new job (IDLE only)
//   in_state     in   initial permutation state
//   in_nrounds   in   rounds to apply (clamped to MAX_ROUNDS)
//   out_valid    out  out_state holds the finished result
//   out_ready    in   consumer accepts out_state
//   out_state    out  permuted state
//   core_c       out  state presented to the round core
//   core_round   out  absolute round index presented to the round core
//   core_rst     out  active-high hold/clear to the round core
//   core_cout    in   round core result
//   core_done    in   round core result valid (only honoured in RUN)
//   dbg_state    out  current FSM state (seq_state_t encoding)
// ---------------------------------------------------------------------------
module gascon_perm_sequencer
    import gascon_pkg::*;
#(
    parameter int CWIDTH     = GASCON_CWIDTH,
    parameter int ROUND_W    = 4,
    parameter int MAX_ROUNDS = GASCON_MAX_ROUNDS  // must not exceed 2**ROUND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CWIDTH-1:0] in_state,
    input  logic [ROUND_W-1:0] in_nrounds,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] out_state,
    output logic [CWIDTH-1:0] core_c,
    output logic [ROUND_W-1:0] core_round,
    output logic              core_rst,
    input  logic [CWIDTH-1:0] core_cout,
    input  logic              core_done,
    output logic [2:0]        dbg_state
);

    // One extra bit so MAX_ROUNDS == 2**ROUND_W is still representable.
    localparam logic [ROUND_W:0]   MAX_EXT   = (ROUND_W+1)'(MAX_ROUNDS);
    localparam logic [ROUND_W-1:0] LAST_RIDX = ROUND_W'(MAX_ROUNDS - 1);

    seq_state_t          r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [CWIDTH-1:0]   r_out_state;
    logic [CWIDTH-1:0]   r_st;
    logic [ROUND_W-1:0]  r_ridx;
    logic                r_core_rst;

    logic [ROUND_W:0]    w_n_clamped;
    logic [ROUND_W-1:0]  w_ridx_start;
    logic                w_n_zero;
    logic                w_accept;

    // Clamp the requested round count, then start at the absolute round index
    // so a shortened permutation always ends on round MAX_ROUNDS-1. With
    // n >= 1 the start index fits in ROUND_W bits; n == 0 never uses it.
    always_comb begin
        w_n_clamped = {1'b0, in_nrounds};
        if (w_n_clamped > MAX_EXT) begin
            w_n_clamped = MAX_EXT;
        end
        w_ridx_start = ROUND_W'(MAX_EXT - w_n_clamped);
        w_n_zero     = (w_n_clamped == '0);
    end

    assign w_accept = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_st        <= '0;
            r_ridx      <= '0;
            r_core_rst  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    r_core_rst <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_st       <= in_state;
                        r_ridx     <= w_ridx_start;
                        if (w_n_zero) begin
                            // Zero rounds: the input is the result.
                            r_out_state <= in_state;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end

                // core_rst stays high for this cycle so the core is cleared
                // between consecutive rounds.
                LOAD: begin
                    r_core_rst <= 1'b0;
                    r_state    <= RUN;
                end

                RUN: begin
                    if (core_done) begin
                        r_core_rst <= 1'b1;
                        r_state    <= LATCH;
                    end
                end

                LATCH: begin
                    r_st <= core_cout;
                    if (r_ridx == LAST_RIDX) begin
                        r_out_state <= core_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_ridx  <= r_ridx + ROUND_W'(1);
                        r_state <= LOAD;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_core_rst <= 1'b1;
                end
            endcase
        end
    end

    // The core sees the working state and round index directly; both are
    // only updated in IDLE/LATCH, so they are stable throughout LOAD and RUN.
    assign core_c     = r_st;
    assign core_round = r_ridx;
    assign core_rst   = r_core_rst;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_state  = r_out_state;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gascon_perm_sequencer.sv
module tb_gascon_perm_sequencer;
    import gascon_pkg::*;

    localparam int CW       = GASCON_CWIDTH;
    localparam int CORE_LAT = 3;

    // Golden results for an all-zero start state with the bench core model
    // (rotate left by one byte, xor rc into the low byte): byte k from the
    // bottom ends up holding rc of round 11-k.
    localparam logic [CW-1:0] G12 = CW'(96'hF0E1D2C3B4A5968778695A4B);
    localparam logic [CW-1:0] G6  = CW'(48'h968778695A4B);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_state;
    logic [3:0]    in_nrounds;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_state;
    logic [CW-1:0] core_c;
    logic [3:0]    core_round;
    logic          core_rst;
    logic [CW-1:0] core_cout;
    logic          core_done;
    logic [2:0]    dbg_state;

    int n_vec;
    int n_miss;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    gascon_perm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_nrounds (in_nrounds),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .core_c     (core_c),
        .core_round (core_round),
        .core_rst   (core_rst),
        .core_cout  (core_cout),
        .core_done  (core_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- behavioural round core ----------------
    function automatic logic [CW-1:0] core_f(input logic [CW-1:0] c, input logic [3:0] r);
        logic [CW-1:0] rot;
        rot = {c[CW-9:0], c[CW-1:CW-8]};
        return rot ^ CW'(rc(r));
    endfunction

    function automatic logic [CW-1:0] golden(input logic [CW-1:0] s, input int n);
        int nc;
        nc = (n > 12) ? 12 : n;
        for (int i = 12 - nc; i < 12; i++) s = core_f(s, 4'(i));
        return s;
    endfunction

    int         core_cnt;
    logic       spur;
    logic       saw_run;
    logic [3:0] rounds_q[$];

    always @(posedge clk) begin
        if (core_rst) core_cnt <= 0;
        else          core_cnt <= core_cnt + 1;
        if (!core_rst) saw_run <= 1'b1;
        if (core_done && !core_rst) rounds_q.push_back(core_round);
    end

    assign core_done = (!core_rst && core_cnt == CORE_LAT - 1) || spur;
    assign core_cout = core_f(core_c, core_round);

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge where out_valid is seen.
    // lat counts rising edges from the accept edge (inclusive).
    task automatic drive_job(input logic [CW-1:0] st, input logic [3:0] n,
                             input bit spur_load, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rounds_q.delete();
        saw_run    = 1'b0;
        in_valid   = 1'b1;
        in_state   = st;
        in_nrounds = n;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_nrounds = 4'd0;
        spur       = spur_load;
        while (!out_valid && lat < 500) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            spur = 1'b0;
        end
        spur = 1'b0;
    endtask

    task automatic complete_job();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_state !== '0) begin n_miss++; $display("FAIL rst_out_state got %h exp 0", out_state); end
        n_vec++; if (core_c !== '0) begin n_miss++; $display("FAIL rst_core_c got %h exp 0", core_c); end
        n_vec++; if (core_round !== 4'd0) begin n_miss++; $display("FAIL rst_core_round got %0d exp 0", core_round); end
        n_vec++; if (core_rst !== 1'b1) begin n_miss++; $display("FAIL rst_core_rst got %b exp 1", core_rst); end
        n_vec++; if (dbg_state !== IDLE) begin n_miss++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_p12();
        int  lat;
        bit  seq_ok;
        drive_job('0, 4'd12, 1'b0, lat);
        n_vec++; if (lat !== 61) begin n_miss++; $display("FAIL p12_latency got %0d exp 61", lat); end
        n_vec++; if (out_state !== G12) begin n_miss++; $display("FAIL p12_state got %h exp %h", out_state, G12); end
        seq_ok = (rounds_q.size() == 12);
        for (int i = 0; i < 12 && seq_ok; i++) if (rounds_q[i] !== 4'(i)) seq_ok = 1'b0;
        n_vec++; if (!seq_ok) begin n_miss++; $display("FAIL p12_rounds got %0d rounds first %0d exp 12 rounds 0..11", rounds_q.size(), rounds_q[0]); end
        complete_job();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL p12_out_valid_drop got %b exp 0", out_valid); end
    endtask

    task automatic test_p6();
        int  lat;
        bit  seq_ok;
        drive_job('0, 4'd6, 1'b0, lat);
        n_vec++; if (lat !== 31) begin n_miss++; $display("FAIL p6_latency got %0d exp 31", lat); end
        n_vec++; if (out_state !== G6) begin n_miss++; $display("FAIL p6_state got %h exp %h", out_state, G6); end
        seq_ok = (rounds_q.size() == 6);
        for (int i = 0; i < 6 && seq_ok; i++) if (rounds_q[i] !== 4'(i + 6)) seq_ok = 1'b0;
        n_vec++; if (!seq_ok) begin n_miss++; $display("FAIL p6_rounds got %0d rounds first %0d exp 6 rounds 6..11", rounds_q.size(), rounds_q[0]); end
        n_vec++; if (rc(rounds_q[0]) !== 8'h96) begin n_miss++; $display("FAIL p6_first_rc got %h exp 96", rc(rounds_q[0])); end
        n_vec++; if (rc(rounds_q[rounds_q.size()-1]) !== 8'h4B) begin n_miss++; $display("FAIL p6_last_rc got %h exp 4b", rc(rounds_q[rounds_q.size()-1])); end
        complete_job();
    endtask

    task automatic test_n0();
        int            lat;
        logic [CW-1:0] pat;
        pat = {5{64'hDEADBEEF_CAFEF00D}};
        drive_job(pat, 4'd0, 1'b0, lat);
        n_vec++; if (lat !== 1) begin n_miss++; $display("FAIL n0_latency got %0d exp 1", lat); end
        n_vec++; if (out_state !== pat) begin n_miss++; $display("FAIL n0_state got %h exp %h", out_state, pat); end
        n_vec++; if (saw_run !== 1'b0) begin n_miss++; $display("FAIL n0_core_rst_low got %b exp 0", saw_run); end
        complete_job();
    endtask

    task automatic test_n15();
        int lat;
        drive_job('0, 4'd15, 1'b0, lat);
        n_vec++; if (lat !== 61) begin n_miss++; $display("FAIL n15_latency got %0d exp 61", lat); end
        n_vec++; if (out_state !== G12) begin n_miss++; $display("FAIL n15_state got %h exp %h", out_state, G12); end
        n_vec++; if (rounds_q.size() !== 12) begin n_miss++; $display("FAIL n15_round_count got %0d exp 12", rounds_q.size()); end
        complete_job();
    endtask

    task automatic test_backpressure();
        int            lat;
        int            bad;
        logic [CW-1:0] pat;
        logic [CW-1:0] exp;
        pat = {5{64'h0123456789ABCDEF}};
        exp = golden(pat, 3);
        out_ready = 1'b0;
        drive_job(pat, 4'd3, 1'b0, lat);
        n_vec++; if (lat !== 16) begin n_miss++; $display("FAIL bp_latency got %0d exp 16", lat); end
        n_vec++; if (out_state !== exp) begin n_miss++; $display("FAIL bp_state got %h exp %h", out_state, exp); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            in_state   = ~pat;
            in_nrounds = 4'd12;
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_state !== exp || in_ready !== 1'b0 || dbg_state !== DONE) bad++;
        end
        n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL bp_hold_stable got %0d bad cycles exp 0", bad); end
        in_valid = 1'b0;
        complete_job();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        n_vec++; if (dbg_state !== IDLE) begin n_miss++; $display("FAIL bp_release_state got %0d exp %0d", dbg_state, IDLE); end
        n_vec++; if (rounds_q.size() !== 3) begin n_miss++; $display("FAIL bp_no_extra_job got %0d rounds exp 3", rounds_q.size()); end
        drive_job('0, 4'd12, 1'b0, lat);
        n_vec++; if (out_state !== G12) begin n_miss++; $display("FAIL bp_next_state got %h exp %h", out_state, G12); end
        complete_job();
    endtask

    task automatic test_reset_mid_run();
        int guard;
        int lat;
        int stray;
        rounds_q.delete();
        in_valid   = 1'b1;
        in_state   = '0;
        in_nrounds = 4'd12;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(core_round == 4'd5 && core_rst == 1'b0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_vec++; if (guard >= 200) begin n_miss++; $display("FAIL mid_reach_round5 got timeout exp round 5 in RUN"); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (dbg_state !== IDLE) begin n_miss++; $display("FAIL mid_rst_state got %0d exp %0d", dbg_state, IDLE); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if (core_rst !== 1'b1) begin n_miss++; $display("FAIL mid_rst_core_rst got %b exp 1", core_rst); end
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        n_vec++; if (stray !== 0) begin n_miss++; $display("FAIL mid_no_output got %0d valid cycles exp 0", stray); end
        drive_job('0, 4'd12, 1'b0, lat);
        n_vec++; if (out_state !== G12) begin n_miss++; $display("FAIL mid_fresh_state got %h exp %h", out_state, G12); end
        n_vec++; if (lat !== 61) begin n_miss++; $display("FAIL mid_fresh_latency got %0d exp 61", lat); end
        complete_job();
    endtask

    task automatic test_spurious_done();
        int lat;
        spur = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spur = 1'b0;
        n_vec++; if (dbg_state !== IDLE) begin n_miss++; $display("FAIL spur_idle_state got %0d exp %0d", dbg_state, IDLE); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL spur_idle_ready got %b exp 1", in_ready); end
        drive_job('0, 4'd12, 1'b1, lat);
        n_vec++; if (lat !== 61) begin n_miss++; $display("FAIL spur_latency got %0d exp 61", lat); end
        n_vec++; if (out_state !== G12) begin n_miss++; $display("FAIL spur_state got %h exp %h", out_state, G12); end
        complete_job();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_state   = '0;
        in_nrounds = 4'd0;
        out_ready  = 1'b1;
        spur       = 1'b0;
        saw_run    = 1'b0;
        @(negedge clk);
        test_reset();
        test_p12();
        test_p6();
        test_n0();
        test_n15();
        test_backpressure();
        test_reset_mid_run();
        test_spurious_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        n_miss++;
        $display("FAIL watchdog got timeout exp all scenarios finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
